// File: rtl/tailors_intersect.sv
// tailors_intersect: sparse-row intersection engine.
// Two coordinate/value streams (A and B) are buffered in small FIFOs and
// merged by index. Coinciding indices produce a match beat; every row pair
// produces exactly one beat with out_last=1 (a match beat or an end beat).
// Optional feature macro: TAILORS_STATS_EN adds saturating match/row
// counters on ports match_count and row_count.

// Small synchronous FIFO with extra-bit pointers (full/empty disambiguation).
module tailors_fifo #(
  parameter int WIDTH = 9,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push_i,
  input  logic [WIDTH-1:0] din_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] dout_o,
  output logic             empty_o,
  output logic             full_o
);

  localparam int PW = $clog2(DEPTH);

  logic [PW:0]      wr_q, wr_d;
  logic [PW:0]      rd_q, rd_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             do_push;
  logic             do_pop;

  assign empty_o = (wr_q == rd_q);
  assign full_o  = (wr_q[PW] != rd_q[PW]) && (wr_q[PW-1:0] == rd_q[PW-1:0]);
  assign dout_o  = mem_q[rd_q[PW-1:0]];

  // A push into a full FIFO is legal only when a pop frees the slot the same cycle.
  assign do_push = push_i && (!full_o || pop_i);
  assign do_pop  = pop_i && !empty_o;

  // Pointer advance; the low PW bits wrap modulo DEPTH naturally.
  always_comb begin
    wr_d = wr_q + (PW+1)'(do_push);
    rd_d = rd_q + (PW+1)'(do_pop);
  end

  // Pointer registers; reset empties the FIFO immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
    end
  end

  // Storage array; contents are don't-care while empty, so no reset.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wr_q[PW-1:0]] <= din_i;
    end
  end

endmodule

// Top-level intersection engine.
module tailors_intersect #(
  parameter int WORD_SIZE   = 4,
  parameter int IDX_SIZE    = 4,
  parameter int BUFFER_SIZE = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 a_valid,
  output logic                 a_ready,
  input  logic [IDX_SIZE-1:0]  a_idx,
  input  logic [WORD_SIZE-1:0] a_val,
  input  logic                 a_last,
  input  logic                 b_valid,
  output logic                 b_ready,
  input  logic [IDX_SIZE-1:0]  b_idx,
  input  logic [WORD_SIZE-1:0] b_val,
  input  logic                 b_last,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [IDX_SIZE-1:0]  out_idx,
  output logic [WORD_SIZE-1:0] out_a,
  output logic [WORD_SIZE-1:0] out_b,
  output logic                 out_match,
  output logic                 out_last
`ifdef TAILORS_STATS_EN
  ,
  output logic [15:0]          match_count,
  output logic [15:0]          row_count
`endif
);

  localparam int EW = IDX_SIZE + WORD_SIZE + 1;

  typedef enum logic [1:0] {
    MERGE   = 2'd0,
    DRAIN_A = 2'd1,
    DRAIN_B = 2'd2
  } state_t;

  state_t state_q, state_d;

  // FIFO plumbing; entries are packed as {idx, val, last}.
  logic [EW-1:0]        a_din, b_din, a_head, b_head;
  logic                 a_empty, b_empty, a_full, b_full;
  logic                 a_push, b_push;
  logic                 pop_a, pop_b;
  logic [IDX_SIZE-1:0]  ah_idx, bh_idx;
  logic [WORD_SIZE-1:0] ah_val, bh_val;
  logic                 ah_last, bh_last;

  // Engine decode.
  logic both_ne, idx_eq, a_lt;
  logic out_load;

  // Beat proposed by the engine this cycle.
  logic                 emit;
  logic [IDX_SIZE-1:0]  emit_idx;
  logic [WORD_SIZE-1:0] emit_a, emit_b;
  logic                 emit_match, emit_last;

  // Output register.
  logic                 out_valid_q;
  logic [IDX_SIZE-1:0]  out_idx_q;
  logic [WORD_SIZE-1:0] out_a_q, out_b_q;
  logic                 out_match_q, out_last_q;

  assign a_ready = !a_full;
  assign b_ready = !b_full;
  assign a_push  = a_valid && a_ready;
  assign b_push  = b_valid && b_ready;
  assign a_din   = {a_idx, a_val, a_last};
  assign b_din   = {b_idx, b_val, b_last};

  tailors_fifo #(.WIDTH(EW), .DEPTH(BUFFER_SIZE)) u_fifo_a (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (a_push),
    .din_i   (a_din),
    .pop_i   (pop_a),
    .dout_o  (a_head),
    .empty_o (a_empty),
    .full_o  (a_full)
  );

  tailors_fifo #(.WIDTH(EW), .DEPTH(BUFFER_SIZE)) u_fifo_b (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (b_push),
    .din_i   (b_din),
    .pop_i   (pop_b),
    .dout_o  (b_head),
    .empty_o (b_empty),
    .full_o  (b_full)
  );

  assign ah_idx  = a_head[EW-1 -: IDX_SIZE];
  assign ah_val  = a_head[WORD_SIZE:1];
  assign ah_last = a_head[0];
  assign bh_idx  = b_head[EW-1 -: IDX_SIZE];
  assign bh_val  = b_head[WORD_SIZE:1];
  assign bh_last = b_head[0];

  assign both_ne = !a_empty && !b_empty;
  assign idx_eq  = (ah_idx == bh_idx);
  assign a_lt    = (ah_idx < bh_idx);

  // The output register can take a new beat when it is empty or being drained.
  assign out_load = !out_valid_q || out_ready;

  // Engine state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= MERGE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; emitting transitions wait for the output register.
  always_comb begin
    state_d = state_q;
    case (state_q)
      MERGE: begin
        if (both_ne) begin
          if (idx_eq) begin
            if (out_load) begin
              if (ah_last && !bh_last) begin
                state_d = DRAIN_B;
              end else if (bh_last && !ah_last) begin
                state_d = DRAIN_A;
              end
            end
          end else if (a_lt) begin
            if (ah_last) begin
              state_d = DRAIN_B;
            end
          end else begin
            if (bh_last) begin
              state_d = DRAIN_A;
            end
          end
        end
      end
      DRAIN_A: begin
        if (!a_empty && ah_last && out_load) begin
          state_d = MERGE;
        end
      end
      DRAIN_B: begin
        if (!b_empty && bh_last && out_load) begin
          state_d = MERGE;
        end
      end
      default: state_d = MERGE;
    endcase
  end

  // Engine outputs: FIFO pops and the beat offered to the output register.
  always_comb begin
    pop_a      = 1'b0;
    pop_b      = 1'b0;
    emit       = 1'b0;
    emit_idx   = '0;
    emit_a     = '0;
    emit_b     = '0;
    emit_match = 1'b0;
    emit_last  = 1'b0;
    case (state_q)
      MERGE: begin
        if (both_ne) begin
          if (idx_eq) begin
            emit       = 1'b1;
            emit_idx   = ah_idx;
            emit_a     = ah_val;
            emit_b     = bh_val;
            emit_match = 1'b1;
            emit_last  = ah_last & bh_last;
            pop_a      = out_load;
            pop_b      = out_load;
          end else if (a_lt) begin
            pop_a = 1'b1;
          end else begin
            pop_b = 1'b1;
          end
        end
      end
      DRAIN_A: begin
        if (!a_empty) begin
          if (ah_last) begin
            emit      = 1'b1;
            emit_last = 1'b1;
            pop_a     = out_load;
          end else begin
            pop_a = 1'b1;
          end
        end
      end
      DRAIN_B: begin
        if (!b_empty) begin
          if (bh_last) begin
            emit      = 1'b1;
            emit_last = 1'b1;
            pop_b     = out_load;
          end else begin
            pop_b = 1'b1;
          end
        end
      end
      default: begin
        pop_a = 1'b0;
        pop_b = 1'b0;
      end
    endcase
  end

  // Output register: loads when free, holds while stalled, clears on reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_idx_q   <= '0;
      out_a_q     <= '0;
      out_b_q     <= '0;
      out_match_q <= 1'b0;
      out_last_q  <= 1'b0;
    end else if (out_load) begin
      out_valid_q <= emit;
      if (emit) begin
        out_idx_q   <= emit_idx;
        out_a_q     <= emit_a;
        out_b_q     <= emit_b;
        out_match_q <= emit_match;
        out_last_q  <= emit_last;
      end
    end
  end

  assign out_valid = out_valid_q;
  assign out_idx   = out_idx_q;
  assign out_a     = out_a_q;
  assign out_b     = out_b_q;
  assign out_match = out_match_q;
  assign out_last  = out_last_q;

`ifdef TAILORS_STATS_EN
  logic        out_fire;
  logic [15:0] match_cnt_q, match_cnt_d;
  logic [15:0] row_cnt_q, row_cnt_d;

  assign out_fire = out_valid_q && out_ready;

  // Saturating handshake counters for matches and completed rows.
  always_comb begin
    match_cnt_d = match_cnt_q;
    row_cnt_d   = row_cnt_q;
    if (out_fire && out_match_q && (match_cnt_q != 16'hFFFF)) begin
      match_cnt_d = match_cnt_q + 16'd1;
    end
    if (out_fire && out_last_q && (row_cnt_q != 16'hFFFF)) begin
      row_cnt_d = row_cnt_q + 16'd1;
    end
  end

  // Counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      match_cnt_q <= '0;
      row_cnt_q   <= '0;
    end else begin
      match_cnt_q <= match_cnt_d;
      row_cnt_q   <= row_cnt_d;
    end
  end

  assign match_count = match_cnt_q;
  assign row_count   = row_cnt_q;
`endif

endmodule

// File: tb/tb_tailors_intersect.sv
// Self-checking bench for tailors_intersect: table of row-pair vectors plus
// hand-written sequences for back-pressure, FIFO-full and mid-row reset.
module tb_tailors_intersect;

  localparam int WS = 4;
  localparam int IS = 4;
  localparam int BS = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          a_valid, a_ready, a_last;
  logic [IS-1:0] a_idx;
  logic [WS-1:0] a_val;
  logic          b_valid, b_ready, b_last;
  logic [IS-1:0] b_idx;
  logic [WS-1:0] b_val;
  logic          out_valid, out_ready, out_match, out_last;
  logic [IS-1:0] out_idx;
  logic [WS-1:0] out_a, out_b;
`ifdef TAILORS_STATS_EN
  logic [15:0]   match_count, row_count;
`endif

  always #5 clk = ~clk;

  tailors_intersect #(.WORD_SIZE(WS), .IDX_SIZE(IS), .BUFFER_SIZE(BS)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .a_valid   (a_valid),
    .a_ready   (a_ready),
    .a_idx     (a_idx),
    .a_val     (a_val),
    .a_last    (a_last),
    .b_valid   (b_valid),
    .b_ready   (b_ready),
    .b_idx     (b_idx),
    .b_val     (b_val),
    .b_last    (b_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_idx   (out_idx),
    .out_a     (out_a),
    .out_b     (out_b),
    .out_match (out_match),
    .out_last  (out_last)
`ifdef TAILORS_STATS_EN
    ,
    .match_count (match_count),
    .row_count   (row_count)
`endif
  );

  typedef struct packed {
    logic [IS-1:0] idx;
    logic [WS-1:0] a;
    logic [WS-1:0] b;
    logic          m;
    logic          l;
  } beat_t;

  typedef struct {
    int                   na, nb, ne;
    logic [3:0][IS-1:0]   ai;
    logic [3:0][WS-1:0]   av;
    logic [3:0]           al;
    logic [3:0][IS-1:0]   bi;
    logic [3:0][WS-1:0]   bv;
    logic [3:0]           bl;
    beat_t [3:0]          ex;
  } vec_t;

  vec_t  vt[8];
  beat_t got_q[$];
  int    checks = 0;
  int    failures = 0;

  // Result monitor: a beat is taken when valid and ready are both high.
  always @(negedge clk) begin : mon
    beat_t bb;
    if (rst_n && out_valid && out_ready) begin
      bb = {out_idx, out_a, out_b, out_match, out_last};
      got_q.push_back(bb);
    end
  end

  function automatic beat_t mk(input int idx, input int a, input int b, input bit m, input bit l);
    beat_t r;
    r = {IS'(idx), WS'(a), WS'(b), m, l};
    return r;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic add_a(input int v, input int i, input int val, input bit l);
    vt[v].ai[vt[v].na] = IS'(i);
    vt[v].av[vt[v].na] = WS'(val);
    vt[v].al[vt[v].na] = l;
    vt[v].na++;
  endtask

  task automatic add_b(input int v, input int i, input int val, input bit l);
    vt[v].bi[vt[v].nb] = IS'(i);
    vt[v].bv[vt[v].nb] = WS'(val);
    vt[v].bl[vt[v].nb] = l;
    vt[v].nb++;
  endtask

  task automatic add_e(input int v, input int i, input int a, input int b, input bit m, input bit l);
    vt[v].ex[vt[v].ne] = mk(i, a, b, m, l);
    vt[v].ne++;
  endtask

  // Drive both streams concurrently, then compare collected beats.
  task automatic run_vec(input int v, input string tag);
    int  ai, bi, cyc;
    bit  a_acc, b_acc;
    ai = 0; bi = 0; cyc = 0;
    got_q.delete();
    while ((ai < vt[v].na || bi < vt[v].nb || got_q.size() < vt[v].ne) && cyc < 60) begin
      a_valid = (ai < vt[v].na);
      if (a_valid) begin
        a_idx = vt[v].ai[ai]; a_val = vt[v].av[ai]; a_last = vt[v].al[ai];
      end
      b_valid = (bi < vt[v].nb);
      if (b_valid) begin
        b_idx = vt[v].bi[bi]; b_val = vt[v].bv[bi]; b_last = vt[v].bl[bi];
      end
      @(negedge clk);
      a_acc = a_valid && a_ready;
      b_acc = b_valid && b_ready;
      @(posedge clk); #1;
      if (a_acc) ai++;
      if (b_acc) bi++;
      cyc++;
    end
    a_valid = 1'b0;
    b_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    check({tag, "_beats"}, got_q.size(), vt[v].ne);
    for (int k = 0; k < vt[v].ne; k++) begin
      if (k < got_q.size()) begin
        check($sformatf("%s_beat%0d", tag, k), got_q[k], vt[v].ex[k]);
      end
    end
  endtask

  task automatic push_a(input int i, input int val, input bit l);
    int n;
    a_valid = 1'b1; a_idx = IS'(i); a_val = WS'(val); a_last = l;
    n = 0;
    @(negedge clk);
    while (!a_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!a_ready) check("push_a_timeout", 32'd0, 32'd1);
    @(posedge clk); #1;
    a_valid = 1'b0;
  endtask

  task automatic push_b(input int i, input int val, input bit l);
    int n;
    b_valid = 1'b1; b_idx = IS'(i); b_val = WS'(val); b_last = l;
    n = 0;
    @(negedge clk);
    while (!b_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!b_ready) check("push_b_timeout", 32'd0, 32'd1);
    @(posedge clk); #1;
    b_valid = 1'b0;
  endtask

  initial begin
    a_valid = 0; a_idx = '0; a_val = '0; a_last = 0;
    b_valid = 0; b_idx = '0; b_val = '0; b_last = 0;
    out_ready = 1'b1;
    for (int v = 0; v < 8; v++) begin
      vt[v].na = 0; vt[v].nb = 0; vt[v].ne = 0;
    end

    // v0: basic intersection with trailing matched last
    add_a(0, 1, 3, 0); add_a(0, 4, 5, 0); add_a(0, 7, 2, 1);
    add_b(0, 4, 6, 0); add_b(0, 7, 1, 1);
    add_e(0, 4, 5, 6, 1, 0); add_e(0, 7, 2, 1, 1, 1);
    // v1: no overlap, A ends first -> end beat from DRAIN_B
    add_a(1, 2, 1, 1);
    add_b(1, 3, 4, 0); add_b(1, 5, 5, 1);
    add_e(1, 0, 0, 0, 0, 1);
    // v2: single-entry matching rows
    add_a(2, 0, 9, 1);
    add_b(2, 0, 2, 1);
    add_e(2, 0, 9, 2, 1, 1);
    // v3: interleaved, no match
    add_a(3, 1, 1, 0); add_a(3, 3, 2, 1);
    add_b(3, 2, 3, 0); add_b(3, 5, 4, 1);
    add_e(3, 0, 0, 0, 0, 1);
    // v4: match on A's last only -> drain B
    add_a(4, 2, 7, 1);
    add_b(4, 0, 1, 0); add_b(4, 2, 8, 0); add_b(4, 6, 3, 1);
    add_e(4, 2, 7, 8, 1, 0); add_e(4, 0, 0, 0, 0, 1);
    // v5: match on B's last only -> drain A
    add_a(5, 1, 5, 0); add_a(5, 3, 4, 0); add_a(5, 9, 1, 1);
    add_b(5, 3, 2, 1);
    add_e(5, 3, 4, 2, 1, 0); add_e(5, 0, 0, 0, 0, 1);
    // v6: full-depth rows, every index matches, max index 15
    add_a(6, 0, 1, 0); add_a(6, 5, 2, 0); add_a(6, 10, 3, 0); add_a(6, 15, 4, 1);
    add_b(6, 0, 15, 0); add_b(6, 5, 14, 0); add_b(6, 10, 13, 0); add_b(6, 15, 12, 1);
    add_e(6, 0, 1, 15, 1, 0); add_e(6, 5, 2, 14, 1, 0);
    add_e(6, 10, 3, 13, 1, 0); add_e(6, 15, 4, 12, 1, 1);
    // v7: B ends first without match -> end beat from DRAIN_A
    add_a(7, 3, 1, 1);
    add_b(7, 1, 2, 1);
    add_e(7, 0, 0, 0, 0, 1);

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid", out_valid, 0);
    check("rst_out_fields", {out_idx, out_a, out_b, out_match, out_last}, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    check("rel_a_ready", a_ready, 1);
    check("rel_b_ready", b_ready, 1);
    check("rel_out_valid", out_valid, 0);
    @(posedge clk); #1;

    run_vec(0, "v0");
    run_vec(1, "v1");
`ifdef TAILORS_STATS_EN
    check("stats_match", match_count, 2);
    check("stats_row", row_count, 2);
`endif
    for (int v = 2; v < 8; v++) begin
      run_vec(v, $sformatf("v%0d", v));
    end

    // FIFO full: four A entries with no B, then one pop
    got_q.delete();
    push_a(5, 1, 0); push_a(6, 2, 0); push_a(7, 3, 0); push_a(8, 4, 1);
    @(negedge clk);
    check("full_a_ready", a_ready, 0);
    check("full_b_ready", b_ready, 1);
    @(posedge clk); #1;
    push_b(9, 5, 0);
    @(negedge clk);
    check("full_hold_a_ready", a_ready, 0);
    @(negedge clk);
    check("full_reassert_a_ready", a_ready, 1);
    repeat (6) @(posedge clk);
    #1;
    check("full_no_early_beat", got_q.size(), 0);
    push_b(10, 6, 1);
    repeat (5) @(posedge clk);
    #1;
    check("full_beats", got_q.size(), 1);
    if (got_q.size() > 0) check("full_end_beat", got_q[0], mk(0, 0, 0, 0, 1));

    // Back-pressure: first beat held while the second waits
    got_q.delete();
    out_ready = 1'b0;
    push_a(1, 1, 0); push_a(2, 2, 1);
    push_b(1, 3, 0); push_b(2, 4, 1);
    repeat (2) @(posedge clk);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      check($sformatf("stall_c%0d", c), {out_valid, out_idx, out_a, out_b, out_match, out_last},
            {1'b1, 4'd1, 4'd1, 4'd3, 1'b1, 1'b0});
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    check("stall_beats", got_q.size(), 2);
    if (got_q.size() > 0) check("stall_beat0", got_q[0], mk(1, 1, 3, 1, 0));
    if (got_q.size() > 1) check("stall_beat1", got_q[1], mk(2, 2, 4, 1, 1));

    // Asynchronous reset mid-row while stalled with out_valid=1
    got_q.delete();
    out_ready = 1'b0;
    push_a(1, 1, 0); push_a(3, 3, 1);
    push_b(1, 2, 0); push_b(3, 4, 1);
    repeat (2) @(posedge clk);
    #1;
    check("prerst_out_valid", out_valid, 1);
    #2;
    rst_n = 1'b0;
    #1;
    check("midrst_out_valid", out_valid, 0);
    check("midrst_out_fields", {out_idx, out_a, out_b, out_match, out_last}, 0);
`ifdef TAILORS_STATS_EN
    check("midrst_stats", {match_count, row_count}, 0);
`endif
    @(posedge clk); #1;
    rst_n = 1'b1;
    out_ready = 1'b1;
    @(negedge clk);
    check("postrst_a_ready", a_ready, 1);
    check("postrst_b_ready", b_ready, 1);
    @(posedge clk); #1;
    run_vec(2, "postrst");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
